// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mc_ctrl_pkg : state, opcode and datapath-select encodings for the sequencer
// Revision    : 1.0
// ============================================================================
package mc_ctrl_pkg;

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEM_ADDR = 4'd2;
  localparam logic [3:0] ST_MEM_RD   = 4'd3;
  localparam logic [3:0] ST_MEM_WB   = 4'd4;
  localparam logic [3:0] ST_MEM_WR   = 4'd5;
  localparam logic [3:0] ST_EXEC     = 4'd6;
  localparam logic [3:0] ST_R_WB     = 4'd7;
  localparam logic [3:0] ST_BRANCH   = 4'd8;
  localparam logic [3:0] ST_JUMP     = 4'd9;
  localparam logic [3:0] ST_ADDI_EX  = 4'd10;
  localparam logic [3:0] ST_ADDI_WB  = 4'd11;

  typedef enum logic [3:0] {
    S_FETCH    = ST_FETCH,
    S_DECODE   = ST_DECODE,
    S_MEM_ADDR = ST_MEM_ADDR,
    S_MEM_RD   = ST_MEM_RD,
    S_MEM_WB   = ST_MEM_WB,
    S_MEM_WR   = ST_MEM_WR,
    S_EXEC     = ST_EXEC,
    S_R_WB     = ST_R_WB,
    S_BRANCH   = ST_BRANCH,
    S_JUMP     = ST_JUMP,
    S_ADDI_EX  = ST_ADDI_EX,
    S_ADDI_WB  = ST_ADDI_WB
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ASB_B       = 2'b00;
  localparam logic [1:0] ASB_FOUR    = 2'b01;
  localparam logic [1:0] ASB_IMM     = 2'b10;
  localparam logic [1:0] ASB_IMM_SL2 = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_mem_watchdog.sv
`default_nettype none
// ============================================================================
// mc_mem_watchdog : counts stalled cycles of a memory access, flags timeout
// Revision        : 1.0
// ============================================================================
module mc_mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_ready,
  input  logic i_clear,
  output logic o_timeout
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign o_timeout = i_active && !i_ready && (count_q == C_LAST);

  // A timeout also restarts the count: an abort from FETCH stays in FETCH.
  always_comb begin
    count_d = count_q;
    if (!i_active || i_ready || i_clear || o_timeout) begin
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mc_register_sequencer.sv
`default_nettype none
// ============================================================================
// mc_register_sequencer : multicycle MIPS control FSM with memory watchdog
// Revision              : 1.0
// ============================================================================
module mc_register_sequencer
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ir_en,
  output logic       mdr_en,
  output logic       ab_en,
  output logic       aluout_en,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       bus_error,
  output logic [3:0] state
);

  state_e state_q;
  state_e state_d;
  logic   wd_active;
  logic   wd_clear;
  logic   wd_timeout;

  assign wd_active = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                     (state_q == S_MEM_WR);
  assign wd_clear  = (state_d != state_q);
  assign state     = state_q;

  mc_mem_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk       (CLK),
    .rst       (RST),
    .i_active  (wd_active),
    .i_ready   (mem_ready),
    .i_clear   (wd_clear),
    .o_timeout (wd_timeout)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    ir_en      = 1'b0;
    mdr_en     = 1'b0;
    ab_en      = 1'b0;
    aluout_en  = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ASB_B;
    alu_op     = ALU_ADD;
    pc_source  = PCS_ALU;
    illegal_op = 1'b0;
    bus_error  = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ASB_FOUR;
        if (mem_ready) begin
          ir_en   = 1'b1;
          pc_en   = 1'b1;
          state_d = S_DECODE;
        end else if (wd_timeout) begin
          bus_error = 1'b1;
        end
      end
      S_DECODE: begin
        // An unknown opcode must not disturb A/B or ALUOut.
        alu_src_b = ASB_IMM_SL2;
        ab_en     = is_known_op(opcode);
        aluout_en = is_known_op(opcode);
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_IMM;
        aluout_en = 1'b1;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          mdr_en  = 1'b1;
          state_d = S_MEM_WB;
        end else if (wd_timeout) begin
          bus_error = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (wd_timeout) begin
          bus_error = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        aluout_en = 1'b1;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PCS_ALUOUT;
        pc_en     = zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_source = PCS_JUMP;
        pc_en     = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_IMM;
        aluout_en = 1'b1;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset is asynchronous, so strobes are masked for its whole duration.
    if (RST) begin
      pc_en      = 1'b0;
      ir_en      = 1'b0;
      mdr_en     = 1'b0;
      ab_en      = 1'b0;
      aluout_en  = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      illegal_op = 1'b0;
      bus_error  = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_register_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mc_register_sequencer : directed + randomized instruction-stream bench
// Revision                 : 1.0
// ============================================================================
module tb_mc_register_sequencer;
  import mc_ctrl_pkg::*;

  localparam int TO = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, ir_en, mdr_en, ab_en, aluout_en, reg_write, mem_read;
  logic       mem_write, iord, mem_to_reg, reg_dst, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       illegal_op, bus_error;
  logic [3:0] state;

  mc_register_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_en(ir_en), .mdr_en(mdr_en), .ab_en(ab_en),
    .aluout_en(aluout_en), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op),
    .bus_error(bus_error), .state(state)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       pc_en, ir_en, mdr_en, ab_en, aluout_en, reg_write;
    logic       mem_read, mem_write, iord, mem_to_reg, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op, bus_error;
  } ctl_t;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic       z;
    logic [5:0] op;
    ctl_t       c;
  } cyc_t;

  ctl_t obs;
  assign obs = {pc_en, ir_en, mdr_en, ab_en, aluout_en, reg_write, mem_read,
                mem_write, iord, mem_to_reg, reg_dst, alu_src_a, alu_src_b,
                alu_op, pc_source, illegal_op, bus_error};

  cyc_t plan[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;

  // Per-state control word as tabulated for each state, strobes excluded.
  function automatic ctl_t moore(input logic [3:0] st);
    ctl_t c = '0;
    case (st)
      ST_FETCH:    begin c.mem_read = 1; c.alu_src_b = 2'b01; end
      ST_DECODE:   begin c.ab_en = 1; c.aluout_en = 1; c.alu_src_b = 2'b11; end
      ST_MEM_ADDR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.aluout_en = 1; end
      ST_MEM_RD:   begin c.mem_read = 1; c.iord = 1; end
      ST_MEM_WB:   begin c.reg_write = 1; c.mem_to_reg = 1; end
      ST_MEM_WR:   begin c.mem_write = 1; c.iord = 1; end
      ST_EXEC:     begin c.alu_src_a = 1; c.alu_op = 2'b10; c.aluout_en = 1; end
      ST_R_WB:     begin c.reg_write = 1; c.reg_dst = 1; end
      ST_BRANCH:   begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_source = 2'b01; end
      ST_JUMP:     begin c.pc_source = 2'b10; c.pc_en = 1; end
      ST_ADDI_EX:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.aluout_en = 1; end
      ST_ADDI_WB:  begin c.reg_write = 1; end
      default:     c = '0;
    endcase
    return c;
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy, input logic z,
                      input logic [5:0] op, input ctl_t c);
    cyc_t e;
    e.st = st; e.rdy = rdy; e.z = z; e.op = op; e.c = c;
    plan.push_back(e);
  endtask

  // Memory phase: `waits` cycles without ready; abort on the TO-th stalled cycle.
  task automatic mem_phase(input logic [3:0] st, input int waits,
                           input logic [5:0] op, output bit aborted);
    ctl_t c;
    aborted = 0;
    for (int i = 0; ; i++) begin
      c = moore(st);
      if (i < waits) begin
        if (i == TO - 1) begin
          c.bus_error = 1;
          push(st, 1'b0, 1'($urandom_range(0, 1)), op, c);
          aborted = 1;
          return;
        end
        push(st, 1'b0, 1'($urandom_range(0, 1)), op, c);
      end else begin
        if (st == ST_FETCH) begin c.ir_en = 1; c.pc_en = 1; end
        if (st == ST_MEM_RD) c.mdr_en = 1;
        push(st, 1'b1, 1'($urandom_range(0, 1)), op, c);
        return;
      end
    end
  endtask

  task automatic plain(input logic [3:0] st, input logic [5:0] op);
    push(st, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op, moore(st));
  endtask

  task automatic gen_instr(input logic [5:0] op, input logic z,
                           input int wf, input int wm);
    bit   ab;
    ctl_t c;
    mem_phase(ST_FETCH, wf, op, ab);
    if (ab) return;
    if (!is_known_op(op)) begin
      c = moore(ST_DECODE);
      c.ab_en = 0; c.aluout_en = 0; c.illegal_op = 1;
      push(ST_DECODE, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op, c);
      return;
    end
    plain(ST_DECODE, op);
    case (op)
      OP_LW: begin
        plain(ST_MEM_ADDR, op);
        mem_phase(ST_MEM_RD, wm, op, ab);
        if (!ab) plain(ST_MEM_WB, op);
      end
      OP_SW: begin
        plain(ST_MEM_ADDR, op);
        mem_phase(ST_MEM_WR, wm, op, ab);
      end
      OP_RTYPE: begin plain(ST_EXEC, op); plain(ST_R_WB, op); end
      OP_ADDI:  begin plain(ST_ADDI_EX, op); plain(ST_ADDI_WB, op); end
      OP_J:     plain(ST_JUMP, op);
      default: begin
        c = moore(ST_BRANCH);
        c.pc_en = z;
        push(ST_BRANCH, 1'($urandom_range(0, 1)), z, op, c);
      end
    endcase
  endtask

  // Drives one planned cycle at the current (post-negedge) time, checks, steps.
  task automatic run_n(input int n);
    cyc_t e;
    for (int k = 0; k < n && plan.size() > 0; k++) begin
      e = plan.pop_front();
      mem_ready = e.rdy; zero = e.z; opcode = e.op;
      #1;
      checks++;
      assert ({state, obs} === {e.st, e.c}) else begin
        errors++;
        $error("FAIL cycle%0d: observed state=%0d ctl=%h, expected state=%0d ctl=%h",
               cyc_no, state, obs, e.st, e.c);
      end
      checks++;
      assert ($onehot0({reg_write, mem_write, mem_read})) else begin
        errors++;
        $error("FAIL excl%0d: observed rw/mw/mr=%b, expected at most one high",
               cyc_no, {reg_write, mem_write, mem_read});
      end
      cyc_no++;
      @(negedge CLK);
      #1;
    end
  endtask

  int waits_tab[9] = '{0, 0, 0, 1, 2, 3, 7, 8, 9};

  initial begin
    logic [5:0] ops[6];
    logic [5:0] op;
    ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};

    // Reset held with memory ready: FETCH selects only, no strobes.
    mem_ready = 1'b1;
    @(negedge CLK); @(negedge CLK); #1;
    checks++;
    assert ({state, obs} === {ST_FETCH, moore(ST_FETCH)}) else begin
      errors++;
      $error("FAIL reset: observed state=%0d ctl=%h, expected state=%0d ctl=%h",
             state, obs, ST_FETCH, moore(ST_FETCH));
    end
    mem_ready = 1'b0;
    RST = 1'b0;

    // Asynchronous reset while lw is stalled in MEM_RD.
    gen_instr(OP_LW, 1'b0, 0, 5);
    run_n(4);
    plan.delete();
    mem_ready = 1'b1;
    #1 RST = 1'b1;
    #1;
    checks++;
    assert (state === ST_FETCH && {mdr_en, reg_write, bus_error, ir_en, pc_en} === 5'b0)
    else begin
      errors++;
      $error("FAIL async_rst: observed state=%0d mdr/rw/be/ir/pc=%b, expected state=0 00000",
             state, {mdr_en, reg_write, bus_error, ir_en, pc_en});
    end
    @(negedge CLK); #1;
    mem_ready = 1'b0;
    RST = 1'b0;

    // Directed cases.
    gen_instr(OP_LW, 1'b0, 0, 0);
    gen_instr(OP_BEQ, 1'b1, 0, 0);
    gen_instr(OP_BEQ, 1'b0, 0, 0);
    gen_instr(OP_RTYPE, 1'b0, 3, 0);
    gen_instr(OP_SW, 1'b0, 0, 8);
    gen_instr(OP_SW, 1'b0, 0, 7);
    gen_instr(6'b111111, 1'b0, 0, 0);
    gen_instr(OP_J, 1'b0, 0, 0);
    gen_instr(OP_ADDI, 1'b0, 0, 0);
    gen_instr(OP_LW, 1'b0, 1, 9);
    gen_instr(OP_J, 1'b0, 8, 0);
    run_n(plan.size());

    // Randomized instruction stream.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 6) == 6) begin
        op = 6'($urandom);
        if (is_known_op(op)) op = 6'b111111;
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      gen_instr(op, 1'($urandom_range(0, 1)),
                waits_tab[$urandom_range(0, 8)], waits_tab[$urandom_range(0, 8)]);
      run_n(plan.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
